// File: rtl/alu_issue_seq_if.sv
// Handshake and ALU drive/capture bundle for alu_issue_seq.
// slave is the sequencer; master is the decoder/consumer/ALU side.
interface alu_issue_seq_if #(
  parameter int WIDTH = 16,
  parameter int FLAGW = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [7:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [7:0]       alu_opcode;
  logic             alu_cin;
  logic [WIDTH-1:0] alu_c;
  logic [FLAGW-1:0] alu_flags;

  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_c;
  logic             resp_err;
  logic [FLAGW-1:0] psr;

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_c, alu_flags, resp_ready,
    output req_ready, alu_a, alu_b, alu_opcode, alu_cin,
           resp_valid, resp_c, resp_err, psr
  );

  modport master (
    output req_valid, req_op, req_a, req_b, alu_c, alu_flags, resp_ready,
    input  req_ready, alu_a, alu_b, alu_opcode, alu_cin,
           resp_valid, resp_c, resp_err, psr
  );
endinterface

// File: rtl/alu_issue_seq.sv
// Issue/capture sequencer between the instruction decoder and the combinational ALU.
// Define ALU_OUT_REG_EN to register the ALU outputs for one extra cycle (EXEC2) before capture.
module alu_issue_seq #(
  parameter int WIDTH = 16,
  parameter int FLAGW = 5
) (
  input logic            clk,
  input logic            reset_n,
  alu_issue_seq_if.slave bus
);
  localparam int CARRY = 3;

`ifdef ALU_OUT_REG_EN
  typedef enum logic [1:0] {IDLE, EXEC, EXEC2, RESP} state_t;
`else
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
`endif

  state_t           state;
  logic             req_ready_q;
  logic             resp_valid_q;
  logic             resp_err_q;
  logic             alu_cin_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [WIDTH-1:0] resp_c_q;
  logic [7:0]       alu_opcode_q;
  logic [FLAGW-1:0] psr_q;

  logic [7:0]       imm8;
  logic [WIDTH-1:0] sext_imm;
  logic [WIDTH-1:0] zext_imm;
  logic [7:0]       dec_op;
  logic [WIDTH-1:0] dec_b;
  logic             dec_err;
  logic [WIDTH-1:0] cap_c;
  logic [FLAGW-1:0] cap_flags;

`ifdef ALU_OUT_REG_EN
  logic [WIDTH-1:0] c_q;
  logic [FLAGW-1:0] flags_q;
  assign cap_c     = c_q;
  assign cap_flags = flags_q;
`else
  assign cap_c     = bus.alu_c;
  assign cap_flags = bus.alu_flags;
`endif

  // Immediate forms carry imm8 split across the opcode low nibble and req_b[3:0].
  assign imm8     = {bus.req_op[3:0], bus.req_b[3:0]};
  assign sext_imm = {{(WIDTH-8){imm8[7]}}, imm8};
  assign zext_imm = {{(WIDTH-8){1'b0}}, imm8};

  always_comb begin
    dec_op  = bus.req_op;
    dec_b   = bus.req_b;
    dec_err = 1'b0;
    case (bus.req_op[7:4])
      4'h0: begin
        case (bus.req_op[3:0])
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hB, 4'hF: ;
          default: dec_err = 1'b1;
        endcase
      end
      4'h8: begin
        case (bus.req_op[3:0])
          4'h0, 4'h1, 4'h4: ;
          default: dec_err = 1'b1;
        endcase
      end
      4'h5: begin dec_op = 8'h05; dec_b = sext_imm; end
      4'h6: begin dec_op = 8'h06; dec_b = zext_imm; end
      4'h7: begin dec_op = 8'h07; dec_b = sext_imm; end
      4'h9: begin dec_op = 8'h09; dec_b = sext_imm; end
      4'hB: begin dec_op = 8'h0B; dec_b = sext_imm; end
      default: dec_err = 1'b1;
    endcase
    if (dec_err) dec_op = 8'h00;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_c_q     <= '0;
      resp_err_q   <= 1'b0;
      psr_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
      alu_cin_q    <= 1'b0;
`ifdef ALU_OUT_REG_EN
      c_q          <= '0;
      flags_q      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            alu_a_q      <= bus.req_a;
            alu_b_q      <= dec_b;
            alu_opcode_q <= dec_op;
            alu_cin_q    <= psr_q[CARRY];
            resp_err_q   <= dec_err;
            req_ready_q  <= 1'b0;
            state        <= EXEC;
          end
        end
`ifdef ALU_OUT_REG_EN
        EXEC: begin
          c_q     <= bus.alu_c;
          flags_q <= bus.alu_flags;
          state   <= EXEC2;
        end
        EXEC2: begin
`else
        EXEC: begin
`endif
          // Undefined requests report zero and leave the carry chain untouched.
          resp_c_q     <= resp_err_q ? '0 : cap_c;
          if (!resp_err_q) psr_q <= cap_flags;
          resp_valid_q <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_c     = resp_c_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.psr        = psr_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_cin    = alu_cin_q;
endmodule

// File: tb/tb_alu_issue_seq.sv
// Self-checking bench for alu_issue_seq: directed table, reset abort, randomized run against a model.
// Uses ALU_OUT_REG_EN (if defined) only to pick the expected capture latency.
module tb_alu_issue_seq;
  localparam int WIDTH = 16;
  localparam int FLAGW = 5;
`ifdef ALU_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [7:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    int          hold;
    logic [7:0]  e_opcode;
    logic [15:0] e_b;
    logic        chk_ops;
    logic        e_cin;
    logic [15:0] e_c;
    logic        e_err;
    logic [4:0]  e_psr;
  } vec_t;

  logic       clk;
  logic       reset_n;
  int         vectors = 0;
  int         miscompares = 0;
  logic [4:0] model_psr;
  vec_t       tbl[12];

  alu_issue_seq_if #(.WIDTH(WIDTH), .FLAGW(FLAGW)) bus ();

  alu_issue_seq #(.WIDTH(WIDTH), .FLAGW(FLAGW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in combinational ALU; flags are ZCFNL.
  function automatic logic [20:0] alu_fn(input logic [7:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic cin);
    logic [16:0] s;
    logic [4:0]  f;
    f = '0;
    case (op)
      8'h05, 8'h06: s = {1'b0, a} + {1'b0, b};
      8'h07:        s = {1'b0, a} + {1'b0, b} + {16'h0000, cin};
      8'h09, 8'h0B: s = {1'b0, a} - {1'b0, b};
      default:      s = {1'b0, a ^ b};
    endcase
    f[4] = (s[15:0] == 16'h0000);
    if (op inside {8'h05, 8'h06, 8'h07, 8'h09, 8'h0B}) f[3] = s[16];
    if (op == 8'h05) f[2] = (a[15] == b[15]) && (s[15] != a[15]);
    if (op inside {8'h05, 8'h09, 8'h0B}) f[1] = s[15];
    if (op == 8'h0B) f[0] = (a < b);
    return {f, s[15:0]};
  endfunction

  always_comb {bus.alu_flags, bus.alu_c} = alu_fn(bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_cin);

  function automatic void ref_decode(input logic [7:0] op, input logic [15:0] b,
                                     output logic [7:0] o, output logic [15:0] ob, output logic err);
    logic [7:0]  imm;
    logic [15:0] sx;
    imm = {op[3:0], b[3:0]};
    sx  = {{8{imm[7]}}, imm};
    err = 1'b0;
    o   = op;
    ob  = b;
    if (op[7:4] == 4'h0 && (op[3:0] inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hB, 4'hF})) begin
    end else if (op[7:4] == 4'h8 && (op[3:0] inside {4'h0, 4'h1, 4'h4})) begin
    end else if (op[7:4] == 4'h5) begin o = 8'h05; ob = sx; end
    else if (op[7:4] == 4'h6) begin o = 8'h06; ob = {8'h00, imm}; end
    else if (op[7:4] == 4'h7) begin o = 8'h07; ob = sx; end
    else if (op[7:4] == 4'h9) begin o = 8'h09; ob = sx; end
    else if (op[7:4] == 4'hB) begin o = 8'h0B; ob = sx; end
    else begin err = 1'b1; o = 8'h00; end
  endfunction

  task automatic ref_model(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                           input int hold, output vec_t v);
    logic [7:0]  dop;
    logic [15:0] db;
    logic        err;
    logic [20:0] r;
    ref_decode(op, b, dop, db, err);
    r = alu_fn(dop, a, db, model_psr[3]);
    v.op       = op;
    v.a        = a;
    v.b        = b;
    v.hold     = hold;
    v.e_opcode = dop;
    v.e_b      = db;
    v.chk_ops  = !err;
    v.e_cin    = model_psr[3];
    v.e_c      = err ? 16'h0000 : r[15:0];
    v.e_err    = err;
    v.e_psr    = err ? model_psr : r[20:16];
    model_psr  = v.e_psr;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic valid, input logic [7:0] op,
                                input logic [15:0] a, input logic [15:0] b);
    bus.req_valid = valid;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
  endtask

  task automatic check_reset(input string tag);
    check_output({tag, "_req_ready"},  32'(bus.req_ready),  32'd1);
    check_output({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check_output({tag, "_resp_c"},     32'(bus.resp_c),     32'd0);
    check_output({tag, "_resp_err"},   32'(bus.resp_err),   32'd0);
    check_output({tag, "_psr"},        32'(bus.psr),        32'd0);
    check_output({tag, "_alu_a"},      32'(bus.alu_a),      32'd0);
    check_output({tag, "_alu_b"},      32'(bus.alu_b),      32'd0);
    check_output({tag, "_alu_opcode"}, 32'(bus.alu_opcode), 32'd0);
    check_output({tag, "_alu_cin"},    32'(bus.alu_cin),    32'd0);
  endtask

  // One full transaction, entered and left on a falling edge with the sequencer idle.
  task automatic issue(input vec_t v);
    int cycles;
    check_output("idle_req_ready", 32'(bus.req_ready), 32'd1);
    apply_stimulus(1'b1, v.op, v.a, v.b);
    @(negedge clk);
    apply_stimulus(1'b0, 8'h00, 16'h0000, 16'h0000);
    check_output("alu_opcode", 32'(bus.alu_opcode), 32'(v.e_opcode));
    if (v.chk_ops) begin
      check_output("alu_a", 32'(bus.alu_a), 32'(v.a));
      check_output("alu_b", 32'(bus.alu_b), 32'(v.e_b));
    end
    check_output("alu_cin",        32'(bus.alu_cin),    32'(v.e_cin));
    check_output("exec_resp_err",  32'(bus.resp_err),   32'(v.e_err));
    check_output("exec_req_ready", 32'(bus.req_ready),  32'd0);
    check_output("exec_resp_vld",  32'(bus.resp_valid), 32'd0);
    cycles = 0;
    while (!bus.resp_valid && cycles < 8) begin
      @(negedge clk);
      cycles++;
    end
    check_output("latency", 32'(cycles), 32'(LAT));
    if (!bus.resp_valid) return;
    check_output("resp_c",   32'(bus.resp_c),   32'(v.e_c));
    check_output("resp_err", 32'(bus.resp_err), 32'(v.e_err));
    check_output("psr",      32'(bus.psr),      32'(v.e_psr));
    for (int i = 0; i < v.hold; i++) begin
      apply_stimulus(1'b1, 8'h05, 16'h00AA, 16'h0055);
      @(negedge clk);
      check_output("hold_resp_valid", 32'(bus.resp_valid), 32'd1);
      check_output("hold_req_ready",  32'(bus.req_ready),  32'd0);
      check_output("hold_resp_c",     32'(bus.resp_c),     32'(v.e_c));
      check_output("hold_psr",        32'(bus.psr),        32'(v.e_psr));
      check_output("hold_alu_opcode", 32'(bus.alu_opcode), 32'(v.e_opcode));
    end
    apply_stimulus(1'b0, 8'h00, 16'h0000, 16'h0000);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check_output("done_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_output("done_req_ready",  32'(bus.req_ready),  32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got still running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t       v;
    logic [7:0] op;
    logic [3:0] his[5];
    int         sel;

    his[0] = 4'h5; his[1] = 4'h6; his[2] = 4'h7; his[3] = 4'h9; his[4] = 4'hB;
    //          op     a         b         hold  opcode b_exp     chk   cin   c         err   psr
    tbl[0]  = '{8'h05, 16'h0005, 16'h0007, 0, 8'h05, 16'h0007, 1'b1, 1'b0, 16'h000C, 1'b0, 5'h00};
    tbl[1]  = '{8'h5F, 16'h0003, 16'h000E, 0, 8'h05, 16'hFFFE, 1'b1, 1'b0, 16'h0001, 1'b0, 5'h08};
    tbl[2]  = '{8'h6F, 16'h0003, 16'h000E, 0, 8'h06, 16'h00FE, 1'b1, 1'b1, 16'h0101, 1'b0, 5'h00};
    tbl[3]  = '{8'h06, 16'hFFFF, 16'h0001, 0, 8'h06, 16'h0001, 1'b1, 1'b0, 16'h0000, 1'b0, 5'h18};
    tbl[4]  = '{8'h07, 16'h0000, 16'h0000, 0, 8'h07, 16'h0000, 1'b1, 1'b1, 16'h0001, 1'b0, 5'h00};
    tbl[5]  = '{8'h9F, 16'h0001, 16'h0001, 3, 8'h09, 16'hFFF1, 1'b1, 1'b0, 16'h0010, 1'b0, 5'h08};
    tbl[6]  = '{8'h0A, 16'h1234, 16'h5678, 0, 8'h00, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 5'h08};
    tbl[7]  = '{8'hB3, 16'h0010, 16'h0002, 0, 8'h0B, 16'h0032, 1'b1, 1'b1, 16'hFFDE, 1'b0, 5'h0B};
    tbl[8]  = '{8'h7C, 16'h0100, 16'h0005, 1, 8'h07, 16'hFFC5, 1'b1, 1'b1, 16'h00C6, 1'b0, 5'h08};
    tbl[9]  = '{8'h81, 16'h00F0, 16'h0004, 0, 8'h81, 16'h0004, 1'b1, 1'b1, 16'h00F4, 1'b0, 5'h00};
    tbl[10] = '{8'h82, 16'h0001, 16'h0001, 2, 8'h00, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 5'h00};
    tbl[11] = '{8'h0F, 16'h1111, 16'h0101, 0, 8'h0F, 16'h0101, 1'b1, 1'b0, 16'h1010, 1'b0, 5'h00};

    reset_n        = 1'b1;
    bus.resp_ready = 1'b0;
    apply_stimulus(1'b0, 8'h00, 16'h0000, 16'h0000);
    #1 reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset("por");
    reset_n = 1'b1;
    @(negedge clk);

    model_psr = 5'h00;
    for (int i = 0; i < 12; i++) begin
      issue(tbl[i]);
      model_psr = tbl[i].e_psr;
    end

    // Leave a nonzero psr, then abort the next request while it sits in EXEC.
    ref_model(8'h06, 16'hFFFF, 16'h0001, 0, v);
    issue(v);
    apply_stimulus(1'b1, 8'h07, 16'h0001, 16'h0001);
    @(negedge clk);
    apply_stimulus(1'b0, 8'h00, 16'h0000, 16'h0000);
    check_output("abort_in_exec", 32'(bus.req_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    check_reset("abort");
    @(negedge clk);
    reset_n   = 1'b1;
    model_psr = 5'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("post_abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    end
    check_output("post_abort_psr", 32'(bus.psr), 32'd0);
    ref_model(8'h07, 16'h0005, 16'h0007, 0, v);
    issue(v);

    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: op = 8'($urandom);
        1: op = {his[$urandom_range(0, 4)], 4'($urandom)};
        2: op = {4'h0, 4'($urandom)};
        default: op = {4'h8, 4'($urandom_range(0, 4))};
      endcase
      ref_model(op, 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)), v);
      issue(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
